// File: rtl/pwr_seq_pkg.sv
// Shared types, defaults and sizing helper for the rail power sequencer.
package pwr_seq_pkg;

    localparam int unsigned DEF_N_RAILS = 4;
    localparam int unsigned DEF_DEB_CYC = 8;
    localparam int unsigned DEF_TMO_CYC = 1000;
    localparam int unsigned DEF_DLY_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_DELAY_UP = 3'd2,
        ST_ON       = 3'd3,
        ST_DOWN     = 3'd4,
        ST_FAULT    = 3'd5
    } seq_state_e;

    // Shared delay/timeout counter must hold the larger of the two limits.
    function automatic int unsigned cnt_width(input int unsigned tmo, input int unsigned dly);
        return $clog2(((tmo > dly) ? tmo : dly) + 1);
    endfunction

endpackage

// File: rtl/pwr_sequencer_rail_debounce.sv
// Per-rail consecutive-sample counter used both to qualify power-good and to detect its loss.
module rail_debounce #(
    parameter int unsigned DEB_CYC = 8
) (
    input  logic clk,
    input  logic arst_n,
    input  logic pg,
    input  logic arm,
    input  logic polarity,
    output logic hit
);
    localparam int unsigned DW = $clog2(DEB_CYC + 1);

    logic [DW-1:0] r_cnt;
    logic          w_match;

    // polarity=1 counts pg high (qualify), polarity=0 counts pg low (loss)
    assign w_match = arm && (pg == polarity);
    assign hit     = w_match && (r_cnt == DW'(DEB_CYC - 1));

    // Clearing on hit keeps a stale count from leaking across a polarity change.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (!w_match || hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/pwr_sequencer.sv
// Ascending power-up / descending power-down rail sequencer with power-good monitoring and fault latch.
module pwr_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int unsigned N_RAILS = DEF_N_RAILS,
    parameter int unsigned DEB_CYC = DEF_DEB_CYC,
    parameter int unsigned TMO_CYC = DEF_TMO_CYC,
    parameter int unsigned DLY_CYC = DEF_DLY_CYC
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clr_fault,
    input  logic [N_RAILS-1:0]         pg,
    output logic [N_RAILS-1:0]         en,
    output logic                       all_good,
    output logic                       busy,
    output logic                       fault,
    output logic [$clog2(N_RAILS)-1:0] fault_rail
);
    localparam int unsigned IDX_W = $clog2(N_RAILS);
    localparam int unsigned CNT_W = cnt_width(TMO_CYC, DLY_CYC);

    seq_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [N_RAILS-1:0] r_en, w_en_nxt;
    logic [IDX_W-1:0]   r_fault_rail, w_frail_nxt;
    logic               r_all_good, r_busy, r_fault;

    logic [N_RAILS-1:0] w_qual_arm, w_loss_arm, w_hit;
    logic               w_qual_hit, w_loss_any, w_tmo, w_dly_done, w_fault_det;
    logic [IDX_W-1:0]   w_loss_rail, w_fault_idx;

    // Rail idx qualifies in RAMP; rails below idx (or all rails in ON) are watched for loss.
    for (genvar g = 0; g < N_RAILS; g++) begin : g_rail
        assign w_qual_arm[g] = (r_state == ST_RAMP) && (r_idx == IDX_W'(g));
        assign w_loss_arm[g] = (r_state == ST_ON) ||
                               (((r_state == ST_RAMP) || (r_state == ST_DELAY_UP)) && (IDX_W'(g) < r_idx));
        rail_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk      (clk),
            .arst_n   (arst_n),
            .pg       (pg[g]),
            .arm      (w_qual_arm[g] | w_loss_arm[g]),
            .polarity (w_qual_arm[g]),
            .hit      (w_hit[g])
        );
    end

    // Lowest-index lost rail is reported.
    always_comb begin
        w_loss_any  = 1'b0;
        w_loss_rail = '0;
        for (int unsigned j = 0; j < N_RAILS; j++) begin
            if (w_hit[j] && w_loss_arm[j] && !w_loss_any) begin
                w_loss_any  = 1'b1;
                w_loss_rail = IDX_W'(j);
            end
        end
    end

    assign w_qual_hit  = |(w_hit & w_qual_arm);
    assign w_tmo       = (r_cnt == CNT_W'(TMO_CYC - 1));
    assign w_dly_done  = (r_cnt == CNT_W'(DLY_CYC - 1));
    assign w_fault_det = w_loss_any || ((r_state == ST_RAMP) && w_tmo && !w_qual_hit);
    assign w_fault_idx = w_loss_any ? w_loss_rail : r_idx;

    // Next-state logic: fault detection overrides stop, which overrides forward progress.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_en_nxt    = r_en;
        w_frail_nxt = r_fault_rail;
        w_cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

        if (w_fault_det) begin
            w_state_nxt = ST_FAULT;
            w_en_nxt    = '0;
            w_frail_nxt = w_fault_idx;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (start && !stop) begin
                        w_state_nxt = ST_RAMP;
                        w_idx_nxt   = '0;
                        w_en_nxt    = N_RAILS'(1);
                    end
                end
                ST_RAMP: begin
                    if (stop) begin
                        w_state_nxt     = ST_DOWN;
                        w_en_nxt[r_idx] = 1'b0;
                        w_cnt_nxt       = '0;
                    end else if (w_qual_hit) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_idx == IDX_W'(N_RAILS - 1)) ? ST_ON : ST_DELAY_UP;
                    end
                end
                ST_DELAY_UP: begin
                    if (stop) begin
                        w_state_nxt     = ST_DOWN;
                        w_en_nxt[r_idx] = 1'b0;
                        w_cnt_nxt       = '0;
                    end else if (w_dly_done) begin
                        w_state_nxt         = ST_RAMP;
                        w_idx_nxt           = r_idx + IDX_W'(1);
                        w_en_nxt[w_idx_nxt] = 1'b1;
                        w_cnt_nxt           = '0;
                    end
                end
                ST_ON: begin
                    w_cnt_nxt = '0;
                    if (stop) begin
                        w_state_nxt           = ST_DOWN;
                        w_idx_nxt             = IDX_W'(N_RAILS - 1);
                        w_en_nxt[N_RAILS - 1] = 1'b0;
                    end
                end
                ST_DOWN: begin
                    if (w_dly_done) begin
                        w_cnt_nxt = '0;
                        if (r_idx == '0) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_idx_nxt           = r_idx - IDX_W'(1);
                            w_en_nxt[w_idx_nxt] = 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    w_cnt_nxt = '0;
                    if (clr_fault && !start) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_en_nxt    = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_en         <= '0;
            r_fault_rail <= '0;
            r_all_good   <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_en         <= w_en_nxt;
            r_fault_rail <= w_frail_nxt;
            r_all_good   <= (w_state_nxt == ST_ON);
            r_busy       <= (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_DELAY_UP) ||
                            (w_state_nxt == ST_DOWN);
            r_fault      <= (w_state_nxt == ST_FAULT);
        end
    end

    assign en         = r_en;
    assign all_good   = r_all_good;
    assign busy       = r_busy;
    assign fault      = r_fault;
    assign fault_rail = r_fault_rail;

endmodule

// File: tb/tb_pwr_sequencer.sv
// Scoreboard bench for pwr_sequencer: expected output-change events are queued with their cycle numbers.
module tb_pwr_sequencer;

    logic       clk = 1'b0;
    logic       arst_n, start, stop, clr_fault;
    logic [3:0] pg, en;
    logic       all_good, busy, fault;
    logic [1:0] fault_rail;

    logic [3:0] en_d1 = '0, en_d2 = '0, pg_ok;
    int         cyc = 0;
    int         n_cmp = 0, n_fail = 0;
    logic [1:0] exp_fr;

    typedef struct {
        int         cyc;
        logic [8:0] val;
    } exp_t;
    exp_t exp_q[$];

    logic [8:0] prev_snap = '0;

    pwr_sequencer #(.N_RAILS(4), .DEB_CYC(8), .TMO_CYC(1000), .DLY_CYC(16)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .stop       (stop),
        .clr_fault  (clr_fault),
        .pg         (pg),
        .en         (en),
        .all_good   (all_good),
        .busy       (busy),
        .fault      (fault),
        .fault_rail (fault_rail)
    );

    always #5 clk = ~clk;

    // Rail model: power-good follows its enable two cycles later, maskable per rail.
    always @(posedge clk) begin
        en_d1 <= en;
        en_d2 <= en_d1;
        cyc   <= cyc + 1;
    end
    assign pg = en_d2 & pg_ok;

    // Monitor: every change of the output bundle must match the next queued event.
    always @(negedge clk) begin
        logic [8:0] snap;
        exp_t       e;
        snap = {en, all_good, busy, fault, fault_rail};
        if (snap !== prev_snap) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: cyc=%0d got {en,ag,busy,fault,fr}=%b required no change", cyc, snap);
            end else begin
                e = exp_q.pop_front();
                if (snap !== e.val || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL out_event: got cyc=%0d %b required cyc=%0d %b", cyc, snap, e.cyc, e.val);
                end
            end
            prev_snap = snap;
        end
    end

    task automatic push(input int c, input logic [3:0] e, input logic ag, input logic b,
                        input logic f, input logic [1:0] fr);
        exp_t x;
        x.cyc = c;
        x.val = {e, ag, b, f, fr};
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_%s: %0d events still pending after %0d cycles, required 0", tag, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic start_seq(output int s);
        s     = cyc + 1;
        start = 1'b1;
        push(s, 4'b0001, 1'b0, 1'b1, 1'b0, exp_fr);
        wait_cyc(s);
        start = 1'b0;
    endtask

    // Remaining power-up steps with pg following en after 2 cycles (10-cycle RAMP, 16-cycle DELAY_UP).
    task automatic push_up_rest(input int s);
        push(s + 26, 4'b0011, 1'b0, 1'b1, 1'b0, exp_fr);
        push(s + 52, 4'b0111, 1'b0, 1'b1, 1'b0, exp_fr);
        push(s + 78, 4'b1111, 1'b0, 1'b1, 1'b0, exp_fr);
        push(s + 88, 4'b1111, 1'b1, 1'b0, 1'b0, exp_fr);
    endtask

    task automatic clear_fault();
        int c;
        c         = cyc + 1;
        clr_fault = 1'b1;
        push(c, 4'b0000, 1'b0, 1'b0, 1'b0, exp_fr);
        wait_cyc(c);
        clr_fault = 1'b0;
        drain(10, "clr");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, g, h;
        arst_n = 1'b1; start = 1'b0; stop = 1'b0; clr_fault = 1'b0;
        pg_ok  = 4'hF; exp_fr = 2'd0;
        #3 arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        settle(1);
        check("rst_en", 32'(en), 32'd0);
        check("rst_all_good", 32'(all_good), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_rail", 32'(fault_rail), 32'd0);

        // Nominal power-up
        start_seq(s);
        push_up_rest(s);
        drain(150, "up");
        check("up_all_good", 32'(all_good), 32'd1);

        // Nominal power-down from ON
        d    = cyc + 1;
        stop = 1'b1;
        push(d,      4'b0111, 1'b0, 1'b1, 1'b0, exp_fr);
        push(d + 16, 4'b0011, 1'b0, 1'b1, 1'b0, exp_fr);
        push(d + 32, 4'b0001, 1'b0, 1'b1, 1'b0, exp_fr);
        push(d + 48, 4'b0000, 1'b0, 1'b1, 1'b0, exp_fr);
        push(d + 64, 4'b0000, 1'b0, 1'b0, 1'b0, exp_fr);
        wait_cyc(d);
        stop = 1'b0;
        drain(120, "down");
        settle(20);

        // Rail 2 never reports good: timeout after 1000 RAMP cycles
        pg_ok = 4'b1011;
        start_seq(s);
        push(s + 26, 4'b0011, 1'b0, 1'b1, 1'b0, exp_fr);
        push(s + 52, 4'b0111, 1'b0, 1'b1, 1'b0, exp_fr);
        exp_fr = 2'd2;
        push(s + 1052, 4'b0000, 1'b0, 1'b0, 1'b1, exp_fr);
        drain(1200, "timeout");
        pg_ok = 4'hF;
        check("tmo_fault_rail", 32'(fault_rail), 32'd2);
        start = 1'b1; clr_fault = 1'b1;
        settle(1);
        start = 1'b0; clr_fault = 1'b0;
        settle(5);
        check("clr_blocked_by_start", 32'(fault), 32'd1);
        clear_fault();
        check("tmo_rail_held", 32'(fault_rail), 32'd2);

        // Glitch rejection on rail 1 in ON: 7 low samples tolerated, 8 fault
        start_seq(s);
        push_up_rest(s);
        drain(150, "glitch_up");
        g     = cyc;
        pg_ok = 4'b1101;
        wait_cyc(g + 7);
        pg_ok = 4'hF;
        settle(20);
        check("glitch7_all_good", 32'(all_good), 32'd1);
        h      = cyc;
        pg_ok  = 4'b1101;
        exp_fr = 2'd1;
        push(h + 8, 4'b0000, 1'b0, 1'b0, 1'b1, exp_fr);
        wait_cyc(h + 8);
        pg_ok = 4'hF;
        drain(20, "glitch8");
        check("glitch_fault_rail", 32'(fault_rail), 32'd1);
        clear_fault();

        // Rail 0 loss and stop in the same cycle: fault wins
        start_seq(s);
        push_up_rest(s);
        drain(150, "simul_up");
        g     = cyc;
        pg_ok = 4'b1110;
        wait_cyc(g + 7);
        stop   = 1'b1;
        exp_fr = 2'd0;
        push(g + 8, 4'b0000, 1'b0, 1'b0, 1'b1, exp_fr);
        wait_cyc(g + 8);
        stop  = 1'b0;
        pg_ok = 4'hF;
        drain(20, "simul");
        clear_fault();

        // stop during DELAY_UP after rail 1 qualified
        start_seq(s);
        push(s + 26, 4'b0011, 1'b0, 1'b1, 1'b0, exp_fr);
        wait_cyc(s + 39);
        stop = 1'b1;
        push(s + 40, 4'b0001, 1'b0, 1'b1, 1'b0, exp_fr);
        push(s + 56, 4'b0000, 1'b0, 1'b1, 1'b0, exp_fr);
        push(s + 72, 4'b0000, 1'b0, 1'b0, 1'b0, exp_fr);
        wait_cyc(s + 40);
        stop = 1'b0;
        drain(100, "dly_stop");
        settle(20);

        // Asynchronous reset in the middle of rail 1 RAMP
        start_seq(s);
        push(s + 26, 4'b0011, 1'b0, 1'b1, 1'b0, exp_fr);
        wait_cyc(s + 30);
        push(s + 30, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        #2 arst_n = 1'b0;
        #1;
        check("arst_en_async", 32'(en), 32'd0);
        check("arst_fault_async", 32'(fault), 32'd0);
        check("arst_busy_async", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        exp_fr = 2'd0;
        settle(2);
        start_seq(s);
        wait_cyc(s + 2);
        stop = 1'b1;
        push(s + 3,  4'b0000, 1'b0, 1'b1, 1'b0, exp_fr);
        push(s + 19, 4'b0000, 1'b0, 1'b0, 1'b0, exp_fr);
        wait_cyc(s + 3);
        stop = 1'b0;
        drain(50, "post_reset");
        settle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwr_sequencer.md
# pwr_sequencer

Power-up/power-down sequencer for a group of supply rails, each monitored by a power-good comparator. It enables rails one at a time in ascending order and waits for each rail's debounced power-good before a fixed inter-rail delay. It disables rails in descending order, and latches a fault with the offending rail index on timeout or loss of power-good. It sits between the system power-control logic and the per-rail comparators and regulator enables.

## Interface
- `N_RAILS`, 4: number of sequenced rails (2..8)
- `DEB_CYC`, 8: consecutive `pg` samples required to qualify a rail, or to declare its loss
- `TMO_CYC`, 1000: maximum cycles in RAMP per rail; must be > `DEB_CYC`
- `DLY_CYC`, 16: inter-rail delay cycles, for both up and down sequencing
- `clk` in 1: single clock, rising edge
- `arst_n` in 1: asynchronous, active-low reset
- `start` in 1: level request to power up
- `stop` in 1: level request to power down
- `clr_fault` in 1: single-cycle pulse; exits FAULT
- `pg` in `N_RAILS`: per-rail power-good, synchronous to `clk`
- `en` out `N_RAILS`: per-rail regulator enable, registered
- `all_good` out 1: high only in ON
- `busy` out 1: high in RAMP, DELAY_UP, DOWN
- `fault` out 1: high in FAULT
- `fault_rail` out `$clog2(N_RAILS)`: index of the failing rail; held until the next fault

## Operation
- States: IDLE, RAMP, DELAY_UP, ON, DOWN, FAULT. Rail index `idx` is the current rail.
- Reset: all outputs 0; state IDLE; `idx` = 0; all counters 0.
- IDLE:
  - `start`=1 and `stop`=0: go to RAMP, `idx`=0, set `en[0]`.
- RAMP:
  - Debounce counter increments on each cycle `pg[idx]`=1; a cycle with `pg[idx]`=0 clears it.
  - Counter reaches `DEB_CYC`: go to ON if `idx`=`N_RAILS`-1, else go to DELAY_UP.
  - Timeout counter reaches `TMO_CYC` first: go to FAULT, `fault_rail`=`idx`.
  - Debounce completion and timeout in the same cycle: debounce wins.
- DELAY_UP:
  - After `DLY_CYC` cycles: `idx`++, set `en[idx]`, go to RAMP.
- Monitoring in RAMP, DELAY_UP, ON:
  - Each already-qualified rail `j` (`j`<`idx`, or all rails in ON) has a loss counter: increments while `pg[j]`=0, clears on `pg[j]`=1.
  - Any loss counter reaching `DEB_CYC`: go to FAULT, `fault_rail` = lowest such `j`.
- ON:
  - `all_good`=1.
  - `stop`=1: go to DOWN with `idx`=`N_RAILS`-1, clear `en[idx]`.
- `stop`=1 in RAMP or DELAY_UP: go to DOWN at the current `idx`, clear `en[idx]`.
- DOWN:
  - Hold `DLY_CYC` cycles.
  - If `idx`=0: go to IDLE. Else `idx`--, clear `en[idx]`, restart the delay.
  - `pg` is ignored; `start` is ignored.
- FAULT:
  - `en` all 0 on the transition edge; `fault`=1.
  - `clr_fault`=1 and `start`=0: go to IDLE, `fault`=0. `clr_fault` while `start`=1 has no effect.
- Priority within one cycle: fault detection > `stop` > `start`.
- `en` is always a contiguous low-order mask: rails 0..k enabled.

## Timing
- `start` sampled high in IDLE at edge 0: `en[0]`=1 after edge 0.
- `pg[idx]` high from the first RAMP cycle: RAMP lasts exactly `DEB_CYC` cycles.
- DELAY_UP and each DOWN step last exactly `DLY_CYC` cycles.
- Ideal power-up latency, `start` edge to `all_good`=1: `N_RAILS`·`DEB_CYC` + (`N_RAILS`-1)·`DLY_CYC` + 1 cycles.
- Fault: `en`=0 and `fault`=1 one edge after the detecting sample.
- Reset asserted mid-sequence: all `en` drop immediately (asynchronous); no down-sequencing.
- Counters saturate; width `$clog2(max(TMO_CYC, DLY_CYC)+1)`.

## Structure
- Package `pwr_seq_pkg`: `seq_state_e` enum, counter-width helper function, default parameter constants.
- One sub-module `rail_debounce`, instantiated per rail:
  - Inputs: `pg`, `arm`, `polarity` (qualify-high or loss-low).
  - Output: `hit` when the consecutive-sample count reaches `DEB_CYC`.
- Top level contains the FSM, `idx`, the delay/timeout counter, and the `en` register.

## Test plan
All cases use `N_RAILS`=4, `DEB_CYC`=8, `TMO_CYC`=1000, `DLY_CYC`=16.
- **Nominal up:** `start`=1; each `pg` follows its `en` after 2 cycles -> `en` steps 0001, 0011, 0111, 1111; `all_good`=1 at cycle 4·10 + 3·16 + 1 = 89.
- **Nominal down:** from ON, pulse `stop` -> `en` steps 0111, 0011, 0001, 0000 at 16-cycle spacing; IDLE 16 cycles after the last step.
- **Timeout:** rail 2 `pg` stuck 0 -> FAULT after 1000 RAMP cycles; `fault_rail`=2, `en`=0000; `clr_fault` with `start`=0 -> IDLE.
- **Glitch rejection:** in ON, `pg[1]` low for 7 cycles -> stays ON; low for 8 cycles -> FAULT, `fault_rail`=1.
- **Simultaneous:** `stop` and a rail-0 loss hit in the same cycle -> FAULT; `stop` in DELAY_UP after rail 1 -> DOWN from `idx`=1, `en` 0001 then 0000.
- **Reset mid-RAMP:** `arst_n` low with `en`=0011 -> `en`=0000 and `fault`=0 without waiting for a clock edge; after release, IDLE.
